// File: rtl/stream_video_filter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_video_filter_pkg : shared widths and reciprocal-divide helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package stream_video_filter_pkg;

    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int NUM_CH = PIX_W / CH_W;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // The shift leaves clog2(N)+1 spare bits above the widest window sum, so
    // the rounding error of the reciprocal never reaches the integer part.
    function automatic int recip_shift(input int fd);
        return CH_W + 2 * clog2(fd * fd) + 1;
    endfunction

    function automatic longint recip_mult(input int fd);
        longint n;
        n = longint'(fd * fd);
        return ((longint'(1) << recip_shift(fd)) + n - 1) / n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_line_buffer : one line of pixel history, one access per clock
// Rev 1.0
// ----------------------------------------------------------------------------
module video_line_buffer
    import stream_video_filter_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int WIDTH  = PIX_W,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the pre-write contents, which lets buffers cascade rows.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_video_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stream_video_filter : AXI4-Stream FILTER_DIM x FILTER_DIM box (mean) filter
// Rev 1.0
// ----------------------------------------------------------------------------
module stream_video_filter
    import stream_video_filter_pkg::*;
#(
    parameter int FILTER_DIM = 5,
    parameter int MAX_WIDTH  = 2048
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] s_axis_video_tdata,
    input  logic             s_axis_video_tvalid,
    output logic             s_axis_video_tready,
    input  logic             s_axis_video_tuser,
    input  logic             s_axis_video_tlast,
    output logic [PIX_W-1:0] m_axis_video_tdata,
    output logic             m_axis_video_tvalid,
    input  logic             m_axis_video_tready,
    output logic             m_axis_video_tuser,
    output logic             m_axis_video_tlast
);

    localparam int N_WIN  = FILTER_DIM * FILTER_DIM;
    localparam int NUM_LB = FILTER_DIM - 1;
    localparam int LB_ARR = (NUM_LB > 0) ? NUM_LB : 1;
    localparam int VS_W   = CH_W + clog2(FILTER_DIM);
    localparam int SUM_W  = CH_W + clog2(N_WIN);
    localparam int SHIFT  = recip_shift(FILTER_DIM);
    localparam int MULT_W = SHIFT + 1;
    localparam int PROD_W = SUM_W + MULT_W;
    localparam int COL_W  = clog2(MAX_WIDTH + 1);
    localparam int AW     = (clog2(MAX_WIDTH) > 0) ? clog2(MAX_WIDTH) : 1;
    localparam int ROW_W  = (clog2(FILTER_DIM) > 0) ? clog2(FILTER_DIM) : 1;

    localparam logic [MULT_W-1:0] RECIP   = MULT_W'(recip_mult(FILTER_DIM));
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(FILTER_DIM - 1);
    localparam logic [COL_W-1:0]  COL_LIM = COL_W'(MAX_WIDTH);

    logic             w_adv;
    logic             w_accept;
    logic             w_in_buf;
    logic [COL_W-1:0] col_q, col_d, w_col_eff;
    logic [ROW_W-1:0] row_q, row_d, w_row_eff;

    logic             m_tvalid_q;
    logic [PIX_W-1:0] m_tdata_q;
    logic             m_tuser_q;
    logic             m_tlast_q;

    assign w_adv    = !m_tvalid_q || m_axis_video_tready;
    assign w_accept = s_axis_video_tvalid && w_adv;
    assign w_in_buf = (w_col_eff < COL_LIM);

    assign s_axis_video_tready = w_adv;
    assign m_axis_video_tvalid = m_tvalid_q;
    assign m_axis_video_tdata  = m_tdata_q;
    assign m_axis_video_tuser  = m_tuser_q;
    assign m_axis_video_tlast  = m_tlast_q;

    // Position of the incoming pixel; tuser restarts the frame even mid-line.
    always_comb begin
        w_col_eff = s_axis_video_tuser ? '0 : col_q;
        w_row_eff = s_axis_video_tuser ? '0 : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (w_accept) begin
            if (s_axis_video_tlast) begin
                col_d = '0;
                row_d = (w_row_eff == ROW_MAX) ? ROW_MAX : w_row_eff + 1'b1;
            end else begin
                col_d = (w_col_eff == COL_LIM) ? COL_LIM : w_col_eff + 1'b1;
                row_d = w_row_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    logic [PIX_W-1:0] w_lb_rd [LB_ARR];
    logic [PIX_W-1:0] w_lb_wr [LB_ARR];

    generate
        if (NUM_LB > 0) begin : g_lb
            for (genvar k = 0; k < NUM_LB; k++) begin : g_row
                if (k == 0) begin : g_first
                    assign w_lb_wr[k] = s_axis_video_tdata;
                end else begin : g_chain
                    assign w_lb_wr[k] = w_lb_rd[k-1];
                end
                video_line_buffer #(
                    .DEPTH  (MAX_WIDTH),
                    .WIDTH  (PIX_W),
                    .ADDR_W (AW)
                ) u_line_buffer (
                    .clk     (clk),
                    .we_i    (w_accept && w_in_buf),
                    .addr_i  (w_col_eff[AW-1:0]),
                    .wdata_i (w_lb_wr[k]),
                    .rdata_o (w_lb_rd[k])
                );
            end
        end else begin : g_no_lb
            assign w_lb_rd[0] = '0;
            assign w_lb_wr[0] = '0;
        end
    endgenerate

    // Buffer k holds the row k+1 above; rows before the frame top are masked.
    logic [VS_W-1:0] w_vsum [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_vsum[c] = VS_W'(s_axis_video_tdata[c*CH_W +: CH_W]);
            for (int k = 0; k < NUM_LB; k++) begin
                if (w_in_buf && (int'(w_row_eff) > k)) begin
                    w_vsum[c] = w_vsum[c] + VS_W'(w_lb_rd[k][c*CH_W +: CH_W]);
                end
            end
        end
    end

    logic [VS_W-1:0] vsum_q [NUM_CH];
    logic            valid1_q, first1_q, user1_q, last1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsum_q   <= '{default: '0};
            valid1_q <= 1'b0;
            first1_q <= 1'b0;
            user1_q  <= 1'b0;
            last1_q  <= 1'b0;
        end else if (w_adv) begin
            valid1_q <= w_accept;
            if (w_accept) begin
                vsum_q   <= w_vsum;
                first1_q <= (w_col_eff == '0);
                user1_q  <= s_axis_video_tuser;
                last1_q  <= s_axis_video_tlast;
            end
        end
    end

    // Horizontal window of column sums; a line start flushes older columns.
    logic [VS_W-1:0]  hwin_q [NUM_CH][FILTER_DIM];
    logic [VS_W-1:0]  hwin_d [NUM_CH][FILTER_DIM];
    logic [SUM_W-1:0] w_sum  [NUM_CH];
    logic [SUM_W-1:0] sum_q  [NUM_CH];
    logic             valid2_q, user2_q, last2_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < FILTER_DIM; k++) begin
                hwin_d[c][k] = hwin_q[c][k];
            end
            if (valid1_q) begin
                hwin_d[c][0] = vsum_q[c];
                for (int k = 1; k < FILTER_DIM; k++) begin
                    hwin_d[c][k] = first1_q ? '0 : hwin_q[c][k-1];
                end
            end
            w_sum[c] = '0;
            for (int k = 0; k < FILTER_DIM; k++) begin
                w_sum[c] = w_sum[c] + SUM_W'(hwin_d[c][k]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < FILTER_DIM; k++) begin
                    hwin_q[c][k] <= '0;
                end
                sum_q[c] <= '0;
            end
            valid2_q <= 1'b0;
            user2_q  <= 1'b0;
            last2_q  <= 1'b0;
        end else if (w_adv) begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                hwin_q  <= hwin_d;
                sum_q   <= w_sum;
                user2_q <= user1_q;
                last2_q <= last1_q;
            end
        end
    end

    logic [PROD_W-1:0] w_prod [NUM_CH];
    logic [PIX_W-1:0]  w_mean;

    always_comb begin
        w_mean = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_prod[c] = PROD_W'(sum_q[c]) * PROD_W'(RECIP);
            w_mean[c*CH_W +: CH_W] = w_prod[c][SHIFT +: CH_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else if (w_adv) begin
            m_tvalid_q <= valid2_q;
            if (valid2_q) begin
                m_tdata_q <= w_mean;
                m_tuser_q <= user2_q;
                m_tlast_q <= last2_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_video_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stream_video_filter : scoreboard bench with a direct window-mean model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stream_video_filter;

    localparam int FD   = 5;
    localparam int MAXW = 2048;
    localparam int W    = 20;
    localparam int H    = 10;

    localparam int MODE_C64  = 0;
    localparam int MODE_CFF  = 1;
    localparam int MODE_RAND = 2;
    localparam int MODE_DOT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tready, m_tuser, m_tlast;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [25:0] exp_q [$];
    logic [23:0] img [0:15][0:31];
    logic [23:0] cap [0:15][0:31];
    int m_row = 0, m_col = 0;
    int o_row = 0, o_col = 0;
    bit rand_ready = 1'b0;
    bit lat_armed  = 1'b0;
    int lat_acc = -1, lat_val = -1;

    stream_video_filter #(.FILTER_DIM(FD), .MAX_WIDTH(MAXW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_tvalid),
        .m_axis_video_tready (m_tready),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mean of the causal window taken straight from the stored frame image.
    function automatic logic [23:0] model_out(input int r, input int c);
        logic [23:0] res;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int sum;
            sum = 0;
            for (int dr = 0; dr < FD; dr++) begin
                for (int dc = 0; dc < FD; dc++) begin
                    int rr;
                    int cc;
                    rr = r - dr;
                    cc = c - dc;
                    if (rr >= 0 && cc >= 0 && (dr == 0 || cc < MAXW))
                        sum += int'(img[rr][cc][ch*8 +: 8]);
                end
            end
            res[ch*8 +: 8] = 8'(sum / (FD * FD));
        end
        return res;
    endfunction

    function automatic logic [23:0] div_pix(input logic [23:0] d);
        logic [23:0] res;
        for (int ch = 0; ch < 3; ch++)
            res[ch*8 +: 8] = 8'(int'(d[ch*8 +: 8]) / (FD * FD));
        return res;
    endfunction

    task automatic model_accept(input logic [23:0] d, input logic u, input logic l);
        if (u) begin
            m_row = 0;
            m_col = 0;
        end
        if (m_row < 16 && m_col < 32) begin
            img[m_row][m_col] = d;
            exp_q.push_back({model_out(m_row, m_col), u, l});
        end
        if (l) begin
            m_row++;
            m_col = 0;
        end else begin
            m_col++;
        end
    endtask

    task automatic send_pixel(input logic [23:0] d, input logic u, input logic l);
        int guard;
        guard    = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            guard++;
            if (guard > 2000) begin
                $display("FAIL send_timeout: s_tready low for %0d cycles, expected accept", guard);
                $fatal(1, "input handshake stuck");
            end
        end
        if (lat_armed && lat_acc < 0) lat_acc = cyc + 1;
        model_accept(d, u, l);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pix_for(input int mode, input int r, input int c);
        logic [31:0] rv;
        case (mode)
            MODE_C64: return 24'h646464;
            MODE_CFF: return 24'hFFFFFF;
            MODE_DOT: return (r == 0 && c == 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                rv = $urandom;
                return rv[23:0];
            end
        endcase
    endfunction

    task automatic send_frame(input int mode, input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < W; c++)
                send_pixel(pix_for(mode, r, c), (r == 0 && c == 0), (c == W - 1));
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                cap[r][c] = 'x;
    endtask

    task automatic check_const_frame(input string tag);
        check({tag, "_r0c0"}, cap[0][0], 24'h040404);
        check({tag, "_r0c4"}, cap[0][4], 24'h141414);
        for (int r = 4; r < H; r++)
            for (int c = 4; c < W; c++)
                check($sformatf("%s_full_r%0dc%0d", tag, r, c), cap[r][c], 24'h646464);
    endtask

    // Output monitor: scoreboard pop, stall stability and backpressure checks.
    initial begin
        logic        prev_stall;
        logic [25:0] prev;
        logic [25:0] e;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_during_stall", {m_tvalid, m_tdata, m_tuser, m_tlast}, {1'b1, prev});
                if (m_tvalid && !m_tready)
                    check("s_tready_when_stalled", s_tready, 0);
                if (lat_armed && lat_val < 0 && m_tvalid)
                    lat_val = cyc;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h, expected no output", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("tdata_r%0dc%0d", o_row, o_col), m_tdata, e[25:2]);
                        check("tuser", m_tuser, e[1]);
                        check("tlast", m_tlast, e[0]);
                    end
                    if (m_tuser) begin
                        o_row = 0;
                        o_col = 0;
                    end
                    if (o_row < 16 && o_col < 32) cap[o_row][o_col] = m_tdata;
                    if (m_tlast) begin
                        o_row++;
                        o_col = 0;
                    end else begin
                        o_col++;
                    end
                end
                prev_stall = m_tvalid && !m_tready;
                prev       = {m_tdata, m_tuser, m_tlast};
            end
        end
    end

    initial begin
        logic [31:0] rv;
        logic [23:0] d7;
        reset    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_m_tdata", m_tdata, 0);
        check("reset_m_tuser", m_tuser, 0);
        check("reset_m_tlast", m_tlast, 0);
        check("reset_s_tready", s_tready, 1);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Constant mid-grey frame with a free-running sink.
        clear_cap();
        rand_ready = 1'b0;
        lat_armed  = 1'b1;
        send_frame(MODE_C64, H);
        drain();
        check("latency_clocks", lat_val - lat_acc + 1, 3);
        lat_armed = 1'b0;
        check_const_frame("c64");

        // Saturated white frame: widest sums.
        clear_cap();
        send_frame(MODE_CFF, H);
        drain();
        check("cff_r9c19", cap[9][19], 24'hFFFFFF);
        check("cff_r1c1", cap[1][1], 24'h282828);

        // Random pixels under random backpressure.
        rand_ready = 1'b1;
        send_frame(MODE_RAND, H);
        send_frame(MODE_RAND, H);
        drain();

        // White frame followed by a single white dot: previous frame masked.
        clear_cap();
        send_frame(MODE_CFF, H);
        send_frame(MODE_DOT, H);
        drain();
        check("dot_r0c0", cap[0][0], 24'h0A0A0A);
        check("dot_r1c0", cap[1][0], 24'h0A0A0A);
        check("dot_r5c0", cap[5][0], 24'h000000);

        // Reset mid-frame, then a clean constant frame.
        rand_ready = 1'b0;
        send_frame(MODE_RAND, 5);
        #2;
        check("pre_reset_m_tvalid", m_tvalid, 1);
        reset = 1'b1;
        #1;
        check("async_reset_m_tvalid", m_tvalid, 0);
        check("async_reset_m_tdata", m_tdata, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        clear_cap();
        send_frame(MODE_C64, H);
        drain();
        check_const_frame("post_reset");

        // Start of frame in the middle of a line.
        rand_ready = 1'b1;
        clear_cap();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                send_pixel(pix_for(MODE_RAND, r, c), (r == 0 && c == 0), (c == W - 1));
        for (int c = 0; c < 7; c++)
            send_pixel(pix_for(MODE_RAND, 3, c), 1'b0, 1'b0);
        rv = $urandom;
        d7 = rv[23:0];
        send_pixel(d7, 1'b1, 1'b0);
        for (int c = 8; c < W; c++)
            send_pixel(pix_for(MODE_RAND, 0, c), 1'b0, (c == W - 1));
        drain();
        check("midline_sof_r0c0", cap[0][0], div_pix(d7));

        send_frame(MODE_RAND, H);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
